// File: rtl/alu_stim_seq.sv
// Stimulus sequencer for a combinational ALU: drives one registered vector per
// cycle (increment, LFSR or op-sweep) and compresses the returned results in a MISR.
module alu_stim_seq #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 4,
  parameter int NUM_OPS     = 15,
  parameter int NUM_VECTORS = 200,
  parameter logic [DATA_W-1:0] A_INIT = DATA_W'(2),
  parameter logic [DATA_W-1:0] B_INIT = DATA_W'(2),
  parameter logic [DATA_W-1:0] A_STEP = DATA_W'(2),
  parameter logic [DATA_W-1:0] B_STEP = DATA_W'(3),
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(1),
  parameter logic [DATA_W-1:0] POLY   = DATA_W'(32'h04C11DB7)
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [1:0]                             mode,
  input  logic [DATA_W-1:0]                      alu_result,
  output logic [CTRL_W-1:0]                      alu_ctrl,
  output logic [DATA_W-1:0]                      op_a,
  output logic [DATA_W-1:0]                      op_b,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(NUM_VECTORS+1)-1:0]       vec_count,
  output logic [DATA_W-1:0]                      signature
);

  localparam int CNT_W = $clog2(NUM_VECTORS+1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_VECTORS-1);
  localparam logic [CTRL_W:0]   NOPS     = (CTRL_W+1)'(NUM_OPS);
  localparam logic [CTRL_W-1:0] OP_LAST  = CTRL_W'(NUM_OPS-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   lfsr_q, lfsr_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sig_q, sig_d;
  logic [DATA_W-1:0]   lfsr_nx;
  logic [CTRL_W-1:0]   ctrl_inc;

  function automatic logic [DATA_W-1:0] galois(input logic [DATA_W-1:0] s);
    return {s[DATA_W-2:0], 1'b0} ^ (s[DATA_W-1] ? POLY : '0);
  endfunction

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction

  // Single subtraction suffices: NUM_OPS > 2**(CTRL_W-1) keeps x-NUM_OPS in range.
  function automatic logic [CTRL_W-1:0] fold(input logic [CTRL_W-1:0] x);
    logic [CTRL_W:0] xe;
    xe = {1'b0, x};
    return (xe >= NOPS) ? CTRL_W'(xe - NOPS) : x;
  endfunction

  assign lfsr_nx  = galois(lfsr_q);
  assign ctrl_inc = (ctrl_q == OP_LAST) ? '0 : ctrl_q + CTRL_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lfsr_d  = lfsr_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            mode_d  = mode;
            sig_d   = '1;
            cnt_d   = '0;
            if (mode == 2'd1) begin
              lfsr_d = SEED;
              a_d    = SEED;
              b_d    = bitrev(SEED);
              ctrl_d = fold(SEED[CTRL_W-1:0]);
            end else begin
              ctrl_d = '0;
              a_d    = A_INIT;
              b_d    = B_INIT;
            end
          end
        end
        RUN: begin
          sig_d = galois(sig_q) ^ alu_result;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            case (mode_q)
              2'd1: begin
                lfsr_d = lfsr_nx;
                a_d    = lfsr_nx;
                b_d    = bitrev(lfsr_nx);
                ctrl_d = fold(lfsr_nx[CTRL_W-1:0]);
              end
              2'd2: begin
                ctrl_d = ctrl_inc;
                if (ctrl_q == OP_LAST) begin
                  a_d = a_q + A_STEP;
                  b_d = b_q + B_STEP;
                end
              end
              default: begin
                ctrl_d = ctrl_inc;
                a_d    = a_q + A_STEP;
                b_d    = b_q + B_STEP;
              end
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      lfsr_q  <= '0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  assign alu_ctrl  = ctrl_q;
  assign op_a      = a_q;
  assign op_b      = b_q;
  assign vec_count = cnt_q;
  assign signature = sig_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_alu_stim_seq.sv
// Directed bench for alu_stim_seq: a default instance driven by a small ALU model
// and a NUM_VECTORS=1 instance with a zero result.
module tb_alu_stim_seq;
  localparam int NV = 200;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start, abort, start2, abort2;
  logic [1:0]  mode;
  logic [31:0] alu_result;
  logic [3:0]  alu_ctrl, alu_ctrl2;
  logic [31:0] op_a, op_b, signature, op_a2, op_b2, signature2;
  logic        busy, done, busy2, done2;
  logic [7:0]  vec_count;
  logic [0:0]  vec_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      default: return a + b + {28'd0, c};
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctrl, op_a, op_b);

  alu_stim_seq dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort), .mode(mode),
    .alu_result(alu_result), .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .vec_count(vec_count), .signature(signature)
  );

  alu_stim_seq #(.NUM_VECTORS(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start2), .abort(abort2), .mode(2'd0),
    .alu_result(32'd0), .alu_ctrl(alu_ctrl2), .op_a(op_a2), .op_b(op_b2),
    .busy(busy2), .done(done2), .vec_count(vec_count2), .signature(signature2)
  );

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] r);
    return ({s[30:0], 1'b0} ^ (s[31] ? POLY : 32'd0)) ^ r;
  endfunction

  function automatic logic [31:0] brev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  function automatic logic [67:0] exp_inc(input int k);
    logic [3:0] c;
    c = 4'(k % 15);
    return {c, 32'(2 + 2*k), 32'(2 + 3*k)};
  endfunction

  function automatic logic [67:0] exp_sweep(input int k);
    logic [3:0] c;
    c = 4'(k % 15);
    return {c, 32'(2 + 2*(k/15)), 32'(2 + 3*(k/15))};
  endfunction

  function automatic logic [31:0] alu_of(input logic [67:0] v);
    return alu_fn(v[67:64], v[63:32], v[31:0]);
  endfunction

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    #12;
    n_tests++;
    if ({alu_ctrl, op_a, op_b, busy, done, vec_count, signature} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got ctrl=%0d a=%h b=%h busy=%b done=%b cnt=%0d sig=%h, want all 0",
               alu_ctrl, op_a, op_b, busy, done, vec_count, signature);
    end
    #2 sys_rst_n = 1'b1;
    step;
  endtask

  task automatic test_mode0;
    logic [31:0] sig;
    logic [67:0] e;
    mode = 2'd0; start = 1'b1; step; start = 1'b0;
    sig = '1;
    for (int k = 0; k < NV; k++) begin
      e = exp_inc(k);
      n_tests++;
      if ({alu_ctrl, op_a, op_b} !== e) begin
        n_fail++;
        $display("FAIL mode0_vec%0d got %h want %h", k, {alu_ctrl, op_a, op_b}, e);
      end
      n_tests++;
      if (busy !== 1'b1 || done !== 1'b0 || vec_count !== 8'(k)) begin
        n_fail++;
        $display("FAIL mode0_run%0d busy=%b done=%b cnt=%0d want 1,0,%0d", k, busy, done, vec_count, k);
      end
      sig = misr(sig, alu_of(e));
      step;
    end
    for (int h = 0; h < 3; h++) begin
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || vec_count !== 8'd200 || signature !== sig ||
          {alu_ctrl, op_a, op_b} !== exp_inc(NV-1)) begin
        n_fail++;
        $display("FAIL mode0_done%0d done=%b busy=%b cnt=%0d sig=%h vec=%h want 1,0,200,%h,%h",
                 h, done, busy, vec_count, signature, {alu_ctrl, op_a, op_b}, sig, exp_inc(NV-1));
      end
      step;
    end
  endtask

  task automatic test_single;
    start2 = 1'b1; step; start2 = 1'b0;
    n_tests++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge1 busy=%b done=%b want 1,0", busy2, done2);
    end
    step;
    n_tests++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || signature2 !== 32'hFB3EE249 || vec_count2 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done done=%b busy=%b sig=%h cnt=%0d want 1,0,fb3ee249,1",
               done2, busy2, signature2, vec_count2);
    end
  endtask

  task automatic test_lfsr;
    logic [31:0] lf, sig;
    logic [3:0]  c, cmax;
    logic [67:0] e;
    mode = 2'd1; start = 1'b1; step; start = 1'b0;
    lf = 32'd1; sig = '1; cmax = '0;
    n_tests++;
    if (op_a !== 32'd1) begin
      n_fail++;
      $display("FAIL lfsr_vec0_a got %h want 1", op_a);
    end
    for (int k = 0; k < NV; k++) begin
      c = (lf[3:0] >= 4'd15) ? lf[3:0] - 4'd15 : lf[3:0];
      e = {c, lf, brev(lf)};
      n_tests++;
      if ({alu_ctrl, op_a, op_b} !== e) begin
        n_fail++;
        $display("FAIL lfsr_vec%0d got %h want %h", k, {alu_ctrl, op_a, op_b}, e);
      end
      if (alu_ctrl > cmax) cmax = alu_ctrl;
      sig = misr(sig, alu_of(e));
      lf = misr(lf, 32'd0);
      step;
      if (k == 0) begin
        n_tests++;
        if (op_a !== 32'd2) begin
          n_fail++;
          $display("FAIL lfsr_vec1_a got %h want 2", op_a);
        end
      end
    end
    n_tests++;
    if (cmax > 4'd14) begin
      n_fail++;
      $display("FAIL lfsr_ctrl_range max ctrl %0d want <= 14", cmax);
    end
    n_tests++;
    if (done !== 1'b1 || signature !== sig) begin
      n_fail++;
      $display("FAIL lfsr_sig done=%b sig=%h want 1,%h", done, signature, sig);
    end
  endtask

  task automatic test_sweep;
    mode = 2'd2; start = 1'b1; step; start = 1'b0;
    for (int k = 0; k < 31; k++) begin
      n_tests++;
      if ({alu_ctrl, op_a, op_b} !== exp_sweep(k)) begin
        n_fail++;
        $display("FAIL sweep_vec%0d got %h want %h", k, {alu_ctrl, op_a, op_b}, exp_sweep(k));
      end
      step;
    end
    abort = 1'b1; step; abort = 1'b0;
  endtask

  task automatic test_mode3;
    mode = 2'd3; start = 1'b1; step; start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({alu_ctrl, op_a, op_b} !== exp_inc(k)) begin
        n_fail++;
        $display("FAIL mode3_vec%0d got %h want %h", k, {alu_ctrl, op_a, op_b}, exp_inc(k));
      end
      step;
    end
    abort = 1'b1; step; abort = 1'b0;
  endtask

  task automatic test_start_abort;
    logic [31:0] sig;
    mode = 2'd0; start = 1'b1; step; start = 1'b0;
    sig = '1;
    for (int k = 0; k < 5; k++) begin
      sig = misr(sig, alu_of(exp_inc(k)));
      step;
    end
    // restart attempt with a different mode must be ignored
    start = 1'b1; mode = 2'd1;
    sig = misr(sig, alu_of(exp_inc(5)));
    step; start = 1'b0;
    n_tests++;
    if ({alu_ctrl, op_a, op_b} !== exp_inc(6) || vec_count !== 8'd6 || busy !== 1'b1 || signature !== sig) begin
      n_fail++;
      $display("FAIL start_in_run vec=%h cnt=%0d busy=%b sig=%h want %h,6,1,%h",
               {alu_ctrl, op_a, op_b}, vec_count, busy, signature, exp_inc(6), sig);
    end
    abort = 1'b1; step; abort = 1'b0;
    for (int h = 0; h < 2; h++) begin
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || signature !== sig || vec_count !== 8'd6 ||
          {alu_ctrl, op_a, op_b} !== exp_inc(6)) begin
        n_fail++;
        $display("FAIL abort_hold%0d busy=%b done=%b sig=%h cnt=%0d want 0,0,%h,6", h, busy, done, signature, vec_count, sig);
      end
      step;
    end
  endtask

  task automatic test_reset_midrun;
    mode = 2'd0; start = 1'b1; step; start = 1'b0;
    step; step; step;
    #2 sys_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({alu_ctrl, op_a, op_b, busy, done, vec_count, signature} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset ctrl=%0d a=%h b=%h busy=%b done=%b cnt=%0d sig=%h want all 0",
               alu_ctrl, op_a, op_b, busy, done, vec_count, signature);
    end
    #1 sys_rst_n = 1'b1;
    step;
    start = 1'b1; step; start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if ({alu_ctrl, op_a, op_b} !== exp_inc(k)) begin
        n_fail++;
        $display("FAIL restart_vec%0d got %h want %h", k, {alu_ctrl, op_a, op_b}, exp_inc(k));
      end
      step;
    end
    abort = 1'b1; step; abort = 1'b0;
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0; mode = 2'd0;
    test_reset;
    test_mode0;
    test_single;
    test_lfsr;
    test_sweep;
    test_mode3;
    test_start_abort;
    test_reset_midrun;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
